uart_rx_frame: RTL and testbench

//   Receive-side frame controller for the UART receive path; consumes the strobes of the receive

---
 rtl/uart_rx_frame_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_frame.sv | 133 +++++++++++++
 tb/tb_uart_rx_frame.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receive constants: generator mode encoding, frame geometry and FSM states.
package uart_rx_frame_pkg;

  localparam logic IDLE_MODE = 1'b0;
  localparam logic BUSY_MODE = 1'b1;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_INDEX = 8;
  localparam int unsigned BITCNT_W   = 4;

  // State encoding doubles as the STATE value seen by the baud-rate generator
  typedef enum logic {
    ST_IDLE = IDLE_MODE,
    ST_BUSY = BUSY_MODE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the raw RX line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic rx,
  output logic rx_sync
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], rx};
    end
  end

  assign rx_sync = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame controller: samples 8N1 frames on generator strobes and
// presents bytes on a VALID/READY port with framing-error and overrun flags.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_BITS   = uart_rx_frame_pkg::DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX,
  input  logic                 BCLK,
  input  logic                 BREAK,
  output logic                 STATE,
  output logic                 START,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 FERR,
  output logic                 OVERRUN
);

  rx_state_e            state, state_n;
  logic [BITCNT_W-1:0]  bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 stopbit, stopbit_n;
  logic                 stop_seen, stop_seen_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 valid_q, valid_n;
  logic                 ferr_q, ferr_n;
  logic                 overrun_q, overrun_n;
  logic                 start;
  logic                 load;
  logic                 accept;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RESET   (RESET),
    .rx      (RX),
    .rx_sync (start)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      shift     <= '0;
      stopbit   <= 1'b0;
      stop_seen <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shift     <= shift_n;
      stopbit   <= stopbit_n;
      stop_seen <= stop_seen_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      ferr_q    <= ferr_n;
      overrun_q <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shift_n     = shift;
    stopbit_n   = stopbit;
    stop_seen_n = stop_seen;
    data_n      = data_q;
    valid_n     = valid_q;
    ferr_n      = 1'b0;
    overrun_n   = overrun_q;
    load        = 1'b0;
    accept      = valid_q && READY;

    case (state)
      ST_IDLE: begin
        // A BCLK with the line high is a glitch that did not last to mid start bit
        if (BCLK && !start) begin
          state_n     = ST_BUSY;
          bitcnt_n    = '0;
          stop_seen_n = 1'b0;
        end
      end
      ST_BUSY: begin
        if (BCLK) begin
          if (bitcnt < BITCNT_W'(STOP_INDEX)) begin
            shift_n  = {start, shift[DATA_BITS-1:1]};
            bitcnt_n = bitcnt + BITCNT_W'(1);
          end else if (!stop_seen) begin
            stopbit_n   = start;
            stop_seen_n = 1'b1;
          end
        end
        // Frame resolves on the BREAK edge; a short frame counts as a framing error
        if (BREAK) begin
          state_n = ST_IDLE;
          if (bitcnt < BITCNT_W'(STOP_INDEX) || !stopbit) begin
            ferr_n = 1'b1;
          end else if (!valid_q || READY) begin
            data_n  = shift;
            valid_n = 1'b1;
            load    = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (accept) begin
      overrun_n = 1'b0;
      if (!load) begin
        valid_n = 1'b0;
      end
    end
  end

  assign STATE   = logic'(state);
  assign START   = start;
  assign DATA    = data_q;
  assign VALID   = valid_q;
  assign FERR    = ferr_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a behavioural divisor-16 baud-rate generator.
module tb_uart_rx_frame;
  import uart_rx_frame_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RX = 1'b1;
  logic       BCLK;
  logic       BREAK;
  logic       STATE;
  logic       START;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY = 1'b0;
  logic       FERR;
  logic       OVERRUN;

  int errors = 0;
  int checks = 0;

  uart_rx_frame #(
    .SYNC_STAGES (2),
    .DATA_BITS   (8)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .RX      (RX),
    .BCLK    (BCLK),
    .BREAK   (BREAK),
    .STATE   (STATE),
    .START   (START),
    .DATA    (DATA),
    .VALID   (VALID),
    .READY   (READY),
    .FERR    (FERR),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Generator model: starts on START low, mid-bit BCLK at count 7, BREAK at end of stop bit
  logic        gen_active;
  int unsigned gen_cnt;
  int unsigned gen_bit;

  assign BCLK  = gen_active && (gen_cnt == 7);
  assign BREAK = gen_active && (gen_bit == 9) && (gen_cnt == 15);

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gen_active <= 1'b0;
      gen_cnt    <= 0;
      gen_bit    <= 0;
    end else if (!gen_active) begin
      if (!START) begin
        gen_active <= 1'b1;
        gen_cnt    <= 0;
        gen_bit    <= 0;
      end
    end else if (BCLK && gen_bit == 0 && START) begin
      gen_active <= 1'b0;
    end else if (gen_cnt == 15) begin
      gen_cnt <= 0;
      if (gen_bit == 9) gen_active <= 1'b0;
      else gen_bit <= gen_bit + 1;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic hold_rx(input logic v, input int n);
    RX = v;
    step(n);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    hold_rx(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] tmp;
      tmp = b;
      hold_rx(tmp[i], 16);
    end
    hold_rx(stop, 16);
    RX = 1'b1;
  endtask

  // Returns just after the edge at which BREAK became visible
  task automatic wait_break(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (BREAK) seen = 1'b1;
    end
    check(tag, {7'b0, seen}, 8'h01);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_state", {7'b0, STATE}, {7'b0, IDLE_MODE});
    check("rst_start", {7'b0, START}, 8'h01);
    check("rst_data", DATA, 8'h00);
    check("rst_valid", {7'b0, VALID}, 8'h00);
    check("rst_ferr", {7'b0, FERR}, 8'h00);
    check("rst_ovr", {7'b0, OVERRUN}, 8'h00);
    RESET = 1'b0;
    step(5);

    // 0xA5 with READY high
    READY = 1'b1;
    send_bits(8'hA5, 1'b1);
    wait_break("a5_break");
    step(1);
    check("a5_data", DATA, 8'hA5);
    check("a5_valid", {7'b0, VALID}, 8'h01);
    check("a5_ferr", {7'b0, FERR}, 8'h00);
    check("a5_ovr", {7'b0, OVERRUN}, 8'h00);
    step(1);
    check("a5_accepted", {7'b0, VALID}, 8'h00);
    step(4);

    // 0x3C with a bad stop bit
    send_bits(8'h3C, 1'b0);
    wait_break("3c_break");
    step(1);
    check("3c_ferr", {7'b0, FERR}, 8'h01);
    check("3c_valid", {7'b0, VALID}, 8'h00);
    check("3c_state", {7'b0, STATE}, {7'b0, IDLE_MODE});
    check("3c_data_kept", DATA, 8'hA5);
    step(1);
    check("3c_ferr_pulse", {7'b0, FERR}, 8'h00);
    step(4);

    // Short glitch on RX
    hold_rx(1'b0, 4);
    RX = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      check("gl_state", {7'b0, STATE}, {7'b0, IDLE_MODE});
      check("gl_valid", {7'b0, VALID}, 8'h00);
      check("gl_ferr", {7'b0, FERR}, 8'h00);
    end

    // Overrun: 0x11 then 0x22 with READY low
    READY = 1'b0;
    send_bits(8'h11, 1'b1);
    wait_break("11_break");
    step(1);
    check("11_data", DATA, 8'h11);
    check("11_valid", {7'b0, VALID}, 8'h01);
    check("11_ovr", {7'b0, OVERRUN}, 8'h00);
    step(4);
    send_bits(8'h22, 1'b1);
    wait_break("22_break");
    step(1);
    check("22_data_kept", DATA, 8'h11);
    check("22_valid", {7'b0, VALID}, 8'h01);
    check("22_ovr", {7'b0, OVERRUN}, 8'h01);
    READY = 1'b1;
    step(1);
    READY = 1'b0;
    check("ovr_acc_valid", {7'b0, VALID}, 8'h00);
    check("ovr_acc_ovr", {7'b0, OVERRUN}, 8'h00);
    step(4);

    // Accept coinciding with load
    send_bits(8'h55, 1'b1);
    wait_break("55_break");
    step(1);
    check("55_data", DATA, 8'h55);
    check("55_valid", {7'b0, VALID}, 8'h01);
    step(4);
    send_bits(8'h66, 1'b1);
    wait_break("66_break");
    READY = 1'b1;
    step(1);
    READY = 1'b0;
    check("66_data", DATA, 8'h66);
    check("66_valid", {7'b0, VALID}, 8'h01);
    check("66_ovr", {7'b0, OVERRUN}, 8'h00);
    step(4);

    // Reset at data bit 4 of 0xF0, released mid-frame
    hold_rx(1'b0, 16 + 4 * 16);
    RX = 1'b1;
    RESET = 1'b1;
    step(8);
    check("mr_state", {7'b0, STATE}, {7'b0, IDLE_MODE});
    check("mr_start", {7'b0, START}, 8'h01);
    check("mr_data", DATA, 8'h00);
    check("mr_valid", {7'b0, VALID}, 8'h00);
    check("mr_ferr", {7'b0, FERR}, 8'h00);
    check("mr_ovr", {7'b0, OVERRUN}, 8'h00);
    RESET = 1'b0;
    hold_rx(1'b1, 8 + 3 * 16 + 16 + 20);
    check("mr_after_valid", {7'b0, VALID}, 8'h00);
    check("mr_after_state", {7'b0, STATE}, {7'b0, IDLE_MODE});
    READY = 1'b1;
    send_bits(8'h81, 1'b1);
    wait_break("81_break");
    step(1);
    check("81_data", DATA, 8'h81);
    check("81_valid", {7'b0, VALID}, 8'h01);
    check("81_ferr", {7'b0, FERR}, 8'h00);
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
